// File: rtl/fadd_issue_wb_pkg.sv
// rtl/fadd_issue_wb_pkg.sv - fpu_pkg: FP32 field positions, fadd latency and result record type
package fpu_pkg;
    localparam int         FP32_W    = 32;
    localparam int         EXP_MSB   = 30;
    localparam int         EXP_LSB   = 23;
    localparam logic [7:0] EXP_MAX   = 8'hFF;
    localparam int         FADD_LAT  = 3;
    localparam int         FADD_TAG_W = 4;

    typedef struct packed {
        logic [FADD_TAG_W-1:0] tag;
        logic [FP32_W-1:0]     data;
        logic [1:0]            flags;
    } fadd_res_t;

    function automatic logic exp_is_max(input logic [FP32_W-1:0] f);
        return f[EXP_MSB:EXP_LSB] == EXP_MAX;
    endfunction

    function automatic logic exp_is_zero(input logic [FP32_W-1:0] f);
        return f[EXP_MSB:EXP_LSB] == '0;
    endfunction
endpackage

// File: rtl/fadd_issue_wb_if.sv
// rtl/fadd_issue_wb_if.sv - request, core and result signals of the fadd issue/writeback wrapper
interface fadd_issue_wb_if #(parameter int TAG_W = 4);
    import fpu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_sub;
    logic [TAG_W-1:0]  in_tag;
    logic [FP32_W-1:0] in_a;
    logic [FP32_W-1:0] in_b;
    logic [FP32_W-1:0] core_a;
    logic [FP32_W-1:0] core_b;
    logic [FP32_W-1:0] core_y;
    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_tag;
    logic [FP32_W-1:0] out_data;
    logic [1:0]        out_flags;

    modport master (
        output in_valid, in_sub, in_tag, in_a, in_b, core_y, out_ready,
        input  in_ready, core_a, core_b, out_valid, out_tag, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_sub, in_tag, in_a, in_b, core_y, out_ready,
        output in_ready, core_a, core_b, out_valid, out_tag, out_data, out_flags
    );
endinterface

// File: rtl/fadd_issue_wb_res_fifo.sv
// rtl/fadd_issue_wb_res_fifo.sv - fadd_res_fifo: circular result buffer, any DEPTH, no bypass
module fadd_res_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = fpu_pkg::fadd_res_t,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  T                 push_data,
    input  logic             pop,
    output T                 head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Credit-based issue upstream guarantees a slot for every completing op.
    assert property (@(posedge clk) disable iff (rst) push |-> !full);
endmodule

// File: rtl/fadd_issue_wb.sv
// rtl/fadd_issue_wb.sv - issue/writeback wrapper for the 3-cycle fadd core
// FADD_EXC_EN adds per-result {ovf, zero} flags; without it out_flags is tied 2'b00.
module fadd_issue_wb
    import fpu_pkg::*;
#(
    parameter int TAG_W    = 4,
    parameter int DEPTH    = 4,
    parameter int CORE_LAT = FADD_LAT
) (
    input  logic           clk,
    input  logic           rst,
    fadd_issue_wb_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [FP32_W-1:0] data;
`ifdef FADD_EXC_EN
        logic [1:0]        flags;
`endif
    } res_t;

    logic [CORE_LAT-1:0] sh_v;
    logic [TAG_W-1:0]    sh_tag [CORE_LAT];
    logic                fire;
    logic                full;
    logic                empty;
    logic [CNT_W-1:0]    count;
    res_t                push_data;
    res_t                head;

    assign fire        = bus.in_valid & bus.in_ready;
    assign bus.core_a  = bus.in_a;
    assign bus.core_b  = {bus.in_b[FP32_W-1] ^ bus.in_sub, bus.in_b[FP32_W-2:0]};
    // Every shadow op owns a FIFO slot, so admission never depends on out_ready.
    assign bus.in_ready = ~full && ((int'(count) + $countones(sh_v)) < DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_v <= '0;
            for (int i = 0; i < CORE_LAT; i++) sh_tag[i] <= '0;
        end else begin
            sh_v[0]   <= fire;
            sh_tag[0] <= bus.in_tag;
            for (int i = 1; i < CORE_LAT; i++) begin
                sh_v[i]   <= sh_v[i-1];
                sh_tag[i] <= sh_tag[i-1];
            end
        end
    end

`ifdef FADD_EXC_EN
    logic [CORE_LAT-1:0] sh_inf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_inf <= '0;
        end else begin
            sh_inf[0] <= exp_is_max(bus.in_a) | exp_is_max(bus.in_b);
            for (int i = 1; i < CORE_LAT; i++) sh_inf[i] <= sh_inf[i-1];
        end
    end

    // Infinite operands yield an infinite sum legitimately; only fresh infinities count as overflow.
    assign push_data.flags = {exp_is_max(bus.core_y) & ~sh_inf[CORE_LAT-1], exp_is_zero(bus.core_y)};
    assign bus.out_flags   = head.flags;
`else
    assign bus.out_flags   = 2'b00;
`endif

    assign push_data.tag  = sh_tag[CORE_LAT-1];
    assign push_data.data = bus.core_y;

    fadd_res_fifo #(
        .DEPTH (DEPTH),
        .T     (res_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (sh_v[CORE_LAT-1]),
        .push_data (push_data),
        .pop       (bus.out_ready),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign bus.out_valid = ~empty;
    assign bus.out_tag   = head.tag;
    assign bus.out_data  = head.data;
endmodule

// File: tb/tb_fadd_issue_wb.sv
// tb/tb_fadd_issue_wb.sv - directed scoreboard bench for fadd_issue_wb with a behavioural fadd core
`timescale 1ns/1ps
module tb_fadd_issue_wb;
    import fpu_pkg::*;

    localparam int TAG_W = 4;
    localparam int DEPTH = 5;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic [1:0]       flags;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     n_vec = 0;
    int     n_err = 0;
    int     n_out = 0;
    exp_t   sbq[$];
    logic [31:0] cp [FADD_LAT];

    always #5 clk = ~clk;

    fadd_issue_wb_if #(.TAG_W(TAG_W)) bus ();

    fadd_issue_wb #(
        .TAG_W    (TAG_W),
        .DEPTH    (DEPTH),
        .CORE_LAT (FADD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'h00) return 0.0;
        if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, 52'h0};
        else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (d[62:52] == 11'h0 || e <= 0) return {d[63], 31'h0};
        if (e >= 255) return {d[63], 8'hFF, 23'h0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [1:0] exp_flags(input logic [31:0] a, input logic [31:0] b, input logic [31:0] y);
`ifdef FADD_EXC_EN
        logic inf_in;
        inf_in = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
        return {(y[30:23] == 8'hFF) && !inf_in, y[30:23] == 8'h00};
`else
        return 2'b00;
`endif
    endfunction

    // Behavioural core: samples a/b every edge, result valid FADD_LAT edges later.
    always @(posedge clk) begin
        cp[0] <= r2f(f2r(bus.core_a) + f2r(bus.core_b));
        for (int i = 1; i < FADD_LAT; i++) cp[i] <= cp[i-1];
    end
    assign bus.core_y = cp[FADD_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_out++;
            if (sbq.size() == 0) begin
                chk("unexpected_result", 32'(bus.out_tag), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("out_tag", 32'(bus.out_tag), 32'(e.tag));
                chk("out_data", bus.out_data, e.data);
                chk("out_flags", 32'(bus.out_flags), 32'(e.flags));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic sub, input logic [TAG_W-1:0] tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expd);
        int w;
        bus.in_valid = 1'b1;
        bus.in_sub   = sub;
        bus.in_tag   = tag;
        bus.in_a     = a;
        bus.in_b     = b;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        if (w == 50) chk("issue_timeout", 32'(bus.in_ready), 32'h1);
        sbq.push_back('{tag: tag, data: expd, flags: exp_flags(a, b, expd)});
        step();
    endtask

    task automatic drain();
        int w;
        w = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while ((sbq.size() != 0 || bus.out_valid === 1'b1) && w < 60) begin
            step();
            w++;
        end
        chk("drain_left", 32'(sbq.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] vals [8];
        int acc;
        int seen;
        int outs0;
        vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        bus.in_valid  = 1'b0;
        bus.in_sub    = 1'b0;
        bus.in_tag    = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_tag", 32'(bus.out_tag), 32'h0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_out_flags", 32'(bus.out_flags), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);

        // 1: single op and its latency
        bus.out_ready = 1'b1;
        issue(1'b0, 4'd5, 32'h3F800000, 32'h40000000, 32'h40400000);
        bus.in_valid = 1'b0;
        step();
        step();
        chk("lat_not_yet", 32'(bus.out_valid), 32'h0);
        step();
        chk("lat_valid", 32'(bus.out_valid), 32'h1);
        chk("lat_data", bus.out_data, 32'h40400000);
        chk("lat_tag", 32'(bus.out_tag), 32'h5);
        drain();

        // 2: eight ops back to back, b = +0 so each result equals a
        for (int i = 0; i < 8; i++) begin
            chk("b2b_in_ready", 32'(bus.in_ready), 32'h1);
            issue(1'b0, TAG_W'(i), vals[i], 32'h0, vals[i]);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("b2b_out_valid", 32'(bus.out_valid), 32'h1);
            step();
        end
        chk("b2b_done", 32'(bus.out_valid), 32'h0);
        drain();

        // 3: backpressure fills exactly DEPTH credits
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sub    = 1'b0;
        bus.in_b      = 32'h0;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            bus.in_tag = TAG_W'(acc + 8);
            bus.in_a   = vals[acc % 8];
            if (bus.in_ready === 1'b1) begin
                sbq.push_back('{tag: TAG_W'(acc + 8), data: vals[acc % 8],
                                flags: exp_flags(vals[acc % 8], 32'h0, vals[acc % 8])});
                acc++;
            end
            step();
        end
        chk("bp_accepted", 32'(acc), 32'(DEPTH));
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'h0);
        chk("bp_head_tag", 32'(bus.out_tag), 32'h8);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("bp_in_ready_back", 32'(bus.in_ready), 32'h1);
        drain();

        // 4: subtract, including exact cancellation
        bus.in_b   = 32'h3F800000;
        bus.in_sub = 1'b1;
        #1;
        chk("sub_core_b", bus.core_b, 32'hBF800000);
        issue(1'b1, 4'd3, 32'h40400000, 32'h3F800000, 32'h40000000);
        issue(1'b1, 4'd4, 32'h40400000, 32'h40400000, 32'h00000000);
        drain();

        // 5: overflow to infinity, then infinite operand
        issue(1'b0, 4'd6, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        issue(1'b0, 4'd7, 32'h7F800000, 32'h7F7FFFFF, 32'h7F800000);
        drain();

        // 6: reset with two queued and two in flight
        bus.out_ready = 1'b0;
        issue(1'b0, 4'd1, vals[0], 32'h0, vals[0]);
        issue(1'b0, 4'd2, vals[1], 32'h0, vals[1]);
        bus.in_valid = 1'b0;
        step();
        issue(1'b0, 4'd3, vals[2], 32'h0, vals[2]);
        issue(1'b0, 4'd4, vals[3], 32'h0, vals[3]);
        bus.in_valid = 1'b0;
        chk("mid_out_valid", 32'(bus.out_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
        sbq.delete();
        outs0 = n_out;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
        bus.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid === 1'b1) seen++;
            step();
        end
        chk("post_rst_emitted", 32'(seen), 32'h0);
        chk("post_rst_pops", 32'(n_out - outs0), 32'h0);
        chk("final_sb_empty", 32'(sbq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
